// File: rtl/mac_vector_unit_if.sv
// Operand/result stream bundle for mac_vector_unit: input beats with job
// configuration, result stream, and a busy indication.
interface mac_vector_unit_if #(
    parameter int NBITS = 8,
    parameter int LANES = 4,
    parameter int CBITS = 8
) ();
    logic [CBITS-1:0]       cfg_len;
    logic                   cfg_relu;
    logic                   in_val;
    logic                   in_rdy;
    logic [LANES*NBITS-1:0] x_in;
    logic [LANES*NBITS-1:0] w_in;
    logic                   out_val;
    logic                   out_rdy;
    logic [LANES*NBITS-1:0] z_out;
    logic                   busy;

    modport master (
        output cfg_len, cfg_relu, in_val, x_in, w_in, out_rdy,
        input  in_rdy, out_val, z_out, busy
    );

    modport slave (
        input  cfg_len, cfg_relu, in_val, x_in, w_in, out_rdy,
        output in_rdy, out_val, z_out, busy
    );
endinterface

// File: rtl/mac_vector_unit.sv
// LANES-wide fixed-point dot-product engine: 3-stage operand/product/accumulate
// pipeline per lane, optional ReLU, saturation to NBITS, valid/ready result.
module mac_vector_unit #(
    parameter int NBITS = 8,
    parameter int DBITS = 4,
    parameter int LANES = 4,
    parameter int CBITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    mac_vector_unit_if.slave   bus
);
    localparam int ABITS = 2*NBITS - DBITS + CBITS;
    localparam int PBITS = 2*NBITS;
    localparam logic signed [ABITS-1:0] SAT_HI = {{(ABITS-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
    localparam logic signed [ABITS-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CBITS-1:0]        len_r;
    logic [CBITS-1:0]        count_r;
    logic                    relu_r;
    logic                    in_rdy_r;
    logic                    busy_r;
    logic                    out_val_r;
    logic [LANES*NBITS-1:0]  z_r;

    logic                    v1_r;
    logic                    v2_r;
    logic signed [NBITS-1:0] x_r    [LANES];
    logic signed [NBITS-1:0] w_r    [LANES];
    logic signed [PBITS-1:0] prod_r [LANES];
    logic signed [ABITS-1:0] acc_r  [LANES];

    logic                    accept_s;
    logic                    handshake_s;
    logic                    drained_s;
    logic [CBITS-1:0]        first_len_s;

    function automatic logic signed [PBITS-1:0] scaled_product(
        input logic signed [NBITS-1:0] x,
        input logic signed [NBITS-1:0] w
    );
        logic signed [PBITS-1:0] full;
        full = PBITS'(x) * PBITS'(w);
        return full >>> DBITS;
    endfunction

    function automatic logic [NBITS-1:0] sat_lane(
        input logic signed [ABITS-1:0] acc,
        input logic                    relu
    );
        logic signed [ABITS-1:0] v;
        v = (relu && acc[ABITS-1]) ? {ABITS{1'b0}} : acc;
        if (v > SAT_HI) begin
            return SAT_HI[NBITS-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[NBITS-1:0];
        end else begin
            return v[NBITS-1:0];
        end
    endfunction

    assign accept_s    = bus.in_val & in_rdy_r;
    assign handshake_s = out_val_r & bus.out_rdy;
    // Both pipeline stages empty means the last beat has reached the accumulator.
    assign drained_s   = (state_r == DRAIN) & ~v1_r & ~v2_r;
    assign first_len_s = (bus.cfg_len == {CBITS{1'b0}}) ? CBITS'(1) : bus.cfg_len;

    assign bus.in_rdy  = in_rdy_r & rst;
    assign bus.out_val = out_val_r;
    assign bus.z_out   = z_r;
    assign bus.busy    = busy_r;

    // Control FSM with registered handshake, busy and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            len_r     <= {CBITS{1'b0}};
            count_r   <= {CBITS{1'b0}};
            relu_r    <= 1'b0;
            in_rdy_r  <= 1'b1;
            busy_r    <= 1'b0;
            out_val_r <= 1'b0;
            z_r       <= {(LANES*NBITS){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        len_r   <= first_len_s;
                        relu_r  <= bus.cfg_relu;
                        count_r <= CBITS'(1);
                        busy_r  <= 1'b1;
                        if (first_len_s == CBITS'(1)) begin
                            state_r  <= DRAIN;
                            in_rdy_r <= 1'b0;
                        end else begin
                            state_r  <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept_s) begin
                        count_r <= count_r + CBITS'(1);
                        if ((count_r + CBITS'(1)) == len_r) begin
                            state_r  <= DRAIN;
                            in_rdy_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drained_s) begin
                        for (int i = 0; i < LANES; i++) begin
                            z_r[i*NBITS +: NBITS] <= sat_lane(acc_r[i], relu_r);
                        end
                        out_val_r <= 1'b1;
                        state_r   <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (handshake_s) begin
                        out_val_r <= 1'b0;
                        busy_r    <= 1'b0;
                        in_rdy_r  <= 1'b1;
                        count_r   <= {CBITS{1'b0}};
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_rdy_r  <= 1'b1;
                    busy_r    <= 1'b0;
                    out_val_r <= 1'b0;
                end
            endcase
        end
    end

    // Per-lane operand, product and accumulator pipeline; bubbles carry v=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                x_r[i]    <= {NBITS{1'b0}};
                w_r[i]    <= {NBITS{1'b0}};
                prod_r[i] <= {PBITS{1'b0}};
                acc_r[i]  <= {ABITS{1'b0}};
            end
        end else begin
            v1_r <= accept_s;
            v2_r <= v1_r;
            for (int i = 0; i < LANES; i++) begin
                if (accept_s) begin
                    x_r[i] <= bus.x_in[i*NBITS +: NBITS];
                    w_r[i] <= bus.w_in[i*NBITS +: NBITS];
                end
                if (v1_r) begin
                    prod_r[i] <= scaled_product(x_r[i], w_r[i]);
                end
                if (handshake_s) begin
                    acc_r[i] <= {ABITS{1'b0}};
                end else if (v2_r) begin
                    acc_r[i] <= acc_r[i] + ABITS'(prod_r[i]);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_vector_unit.sv
// Self-checking bench: directed cases with literal results plus randomized
// traffic compared every cycle against a job-level dot-product model.
module tb_mac_vector_unit;
    localparam int NBITS = 8;
    localparam int DBITS = 4;
    localparam int LANES = 4;
    localparam int CBITS = 8;

    logic clk = 1'b0;
    logic rst;

    mac_vector_unit_if #(.NBITS(NBITS), .LANES(LANES), .CBITS(CBITS)) bus ();

    mac_vector_unit #(.NBITS(NBITS), .DBITS(DBITS), .LANES(LANES), .CBITS(CBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job is a list of accepted beats; its result appears
    // three edges after the last beat and stays until the consumer takes it.
    longint      edge_n = 0;
    bit          in_job = 1'b0;
    bit          pending = 1'b0;
    int          len_m;
    bit          relu_m;
    int          cnt_m;
    int          sum_m [LANES];
    longint      due_m;
    logic [31:0] zres_m;
    logic [31:0] z_model = 32'h0;
    logic        s_rst, s_val, s_ordy, s_relu;
    logic [31:0] s_x, s_w;
    logic [7:0]  s_len;

    always @(posedge clk) begin
        edge_n++;
        s_rst  = rst;
        s_val  = bus.in_val;
        s_ordy = bus.out_rdy;
        s_x    = bus.x_in;
        s_w    = bus.w_in;
        s_len  = bus.cfg_len;
        s_relu = bus.cfg_relu;
        if (!s_rst) begin
            in_job  = 1'b0;
            pending = 1'b0;
            z_model = 32'h0;
        end else if (pending) begin
            if (edge_n > due_m && s_ordy) pending = 1'b0;
        end else if (s_val) begin
            if (!in_job) begin
                in_job = 1'b1;
                len_m  = (s_len == 8'd0) ? 1 : int'(s_len);
                relu_m = s_relu;
                cnt_m  = 0;
                for (int i = 0; i < LANES; i++) sum_m[i] = 0;
            end
            for (int i = 0; i < LANES; i++) begin
                int p;
                p = int'($signed(s_x[i*8 +: 8])) * int'($signed(s_w[i*8 +: 8]));
                sum_m[i] += (p >>> DBITS);
            end
            cnt_m++;
            if (cnt_m == len_m) begin
                in_job  = 1'b0;
                pending = 1'b1;
                due_m   = edge_n + 3;
                for (int i = 0; i < LANES; i++) begin
                    int v;
                    v = sum_m[i];
                    if (relu_m && v < 0) v = 0;
                    if (v > 127) v = 127;
                    if (v < -128) v = -128;
                    zres_m[i*8 +: 8] = 8'(v);
                end
            end
        end
        #1;
        if (pending && edge_n == due_m) z_model = zres_m;
        check("out_val", {31'd0, bus.out_val}, {31'd0, pending && edge_n >= due_m});
        check("z_out",   bus.z_out, z_model);
        check("in_rdy",  {31'd0, bus.in_rdy}, {31'd0, s_rst && !pending});
        check("busy",    {31'd0, bus.busy}, {31'd0, in_job || pending});
    end

    task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] w,
                         input int len, input bit relu);
        @(negedge clk);
        bus.in_val   = v;
        bus.x_in     = x;
        bus.w_in     = w;
        bus.cfg_len  = 8'(len);
        bus.cfg_relu = relu;
    endtask

    task automatic run_job(input string name, input int len, input bit relu,
                           input logic [31:0] x, input logic [31:0] w,
                           input int beats, input int gap, input int hold,
                           input logic [31:0] exp_z);
        int lat;
        bus.out_rdy = 1'b0;
        for (int b = 0; b < beats; b++) begin
            drive(1'b1, x, w, len, relu);
            if (b != beats - 1) begin
                for (int g = 0; g < gap; g++) drive(1'b0, 32'h0, 32'h0, len, relu);
            end
        end
        drive(1'b0, 32'h0, 32'h0, len, relu);
        lat = 1;
        while (!bus.out_val && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_z"}, bus.z_out, exp_z);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({name, "_hold_z"}, bus.z_out, exp_z);
            check({name, "_hold_in_rdy"}, {31'd0, bus.in_rdy}, 32'd0);
            check({name, "_hold_busy"}, {31'd0, bus.busy}, 32'd1);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        check({name, "_val_drop"}, {31'd0, bus.out_val}, 32'd0);
        check({name, "_rdy_back"}, {31'd0, bus.in_rdy}, 32'd1);
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_val   = 1'b0;
        bus.x_in     = 32'h0;
        bus.w_in     = 32'h0;
        bus.cfg_len  = 8'd0;
        bus.cfg_relu = 1'b0;
        bus.out_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_val", {31'd0, bus.out_val}, 32'd0);
        check("reset_z", bus.z_out, 32'h0);
        check("reset_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_rdy", {31'd0, bus.in_rdy}, 32'd1);

        run_job("t1", 3, 1'b0, 32'h00000010, 32'h00000020, 3, 0, 0, 32'h00000060);
        run_job("t2a", 2, 1'b0, 32'h00001000, 32'h0000F000, 2, 0, 0, 32'h0000E000);
        run_job("t2b", 2, 1'b1, 32'h00001000, 32'h0000F000, 2, 0, 0, 32'h00000000);
        run_job("t3p", 4, 1'b0, 32'h7F7F7F7F, 32'h7F7F7F7F, 4, 0, 0, 32'h7F7F7F7F);
        run_job("t3n", 4, 1'b0, 32'h7F7F7F7F, 32'h80808080, 4, 0, 0, 32'h80808080);
        run_job("t4a", 4, 1'b0, 32'h08040201, 32'h10101010, 4, 0, 0, 32'h20100804);
        run_job("t4b", 4, 1'b0, 32'h08040201, 32'h10101010, 4, 2, 0, 32'h20100804);
        run_job("t4z", 0, 1'b0, 32'h00000010, 32'h00000030, 1, 0, 0, 32'h00000030);
        run_job("t5", 2, 1'b0, 32'h10101010, 32'h20202020, 2, 1, 10, 32'h40404040);
        run_job("t5n", 1, 1'b0, 32'h00000010, 32'h00000010, 1, 0, 0, 32'h00000010);

        drive(1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 4, 1'b0);
        drive(1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 4, 1'b0);
        @(negedge clk);
        bus.in_val = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_out_val", {31'd0, bus.out_val}, 32'd0);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        run_job("t6", 1, 1'b0, 32'h00000010, 32'h00000010, 1, 0, 0, 32'h00000010);

        for (int c = 0; c < 4000; c++) begin
            logic [31:0] x, w;
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                x = $urandom;
                w = $urandom;
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    x[i*8 +: 8] = 8'($urandom_range(0, 80)) - 8'd40;
                    w[i*8 +: 8] = 8'($urandom_range(0, 80)) - 8'd40;
                end
            end
            rst          = ($urandom_range(0, 399) != 0);
            bus.in_val   = ($urandom_range(0, 9) < 7);
            bus.x_in     = x;
            bus.w_in     = w;
            bus.cfg_len  = ($urandom_range(0, 19) == 0) ? 8'd20 : 8'($urandom_range(0, 6));
            bus.cfg_relu = 1'($urandom_range(0, 1));
            bus.out_rdy  = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        bus.in_val = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
